// File: rtl/pc_sequencer_pkg.sv
// Shared types and widths for the program sequencer.
package pc_seq_pkg;

    localparam int unsigned PC_W      = 12;
    localparam int unsigned STK_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Handshake, decoder-control and fetch-address bundle between the sequencer and its environment.
interface pc_sequencer_if
    import pc_seq_pkg::*;
#(
    parameter int unsigned D = PC_W
) ();

    logic         start;
    logic         stall;
    logic         absjump_en;
    logic         branch_en;
    logic         cond_flag;
    logic         call_en;
    logic         ret_en;
    logic         halt;
    logic [D-1:0] target;
    logic [D-1:0] prog_ctr;
    logic         fetch_valid;
    logic         done;
    logic         stk_err;

    // Environment side: drives controls, observes fetch address and status
    modport master (
        output start, stall, absjump_en, branch_en, cond_flag,
        output call_en, ret_en, halt, target,
        input  prog_ctr, fetch_valid, done, stk_err
    );

    // Sequencer side
    modport slave (
        input  start, stall, absjump_en, branch_en, cond_flag,
        input  call_en, ret_en, halt, target,
        output prog_ctr, fetch_valid, done, stk_err
    );

endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// LIFO return-address stack; overflowing pushes and underflowing pops are ignored here
// and flagged by the caller using full/empty.
module ret_stack #(
    parameter int unsigned D      = 12,
    parameter int unsigned SDEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] din,
    output logic [D-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int unsigned AW = $clog2(SDEPTH);
    localparam int unsigned PW = AW + 1;

    logic [D-1:0]  mem [SDEPTH];
    logic [PW-1:0] ptr;

    // Stack pointer: number of valid entries, 0..SDEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (push && !full) begin
            ptr <= ptr + PW'(1);
        end else if (pop && !empty) begin
            ptr <= ptr - PW'(1);
        end
    end

    // Entry storage; wiped on reset so nothing survives an abort
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(SDEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full && !clr) begin
            mem[AW'(ptr)] <= din;
        end
    end

    assign dout  = mem[AW'(ptr - PW'(1))];
    assign empty = (ptr == '0);
    assign full  = (ptr == PW'(SDEPTH));

endmodule

// File: rtl/pc_sequencer.sv
// Program sequencer: start/run/stall/halt control and next-PC resolution with a return stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned D      = PC_W,
    parameter int unsigned SDEPTH = STK_DEPTH
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

    seq_state_t   state_q;
    seq_state_t   state_d;
    logic [D-1:0] pc_q;
    logic [D-1:0] pc_d;
    logic [D-1:0] pc_inc;
    logic         err_q;
    logic         err_d;
    logic         stk_push;
    logic         stk_pop;
    logic         stk_clr;
    logic [D-1:0] stk_dout;
    logic         stk_empty;
    logic         stk_full;
    logic         accept_start;
    logic         advance;

    // Wraps modulo 2**D; also the pushed return address
    assign pc_inc       = pc_q + D'(1);
    assign accept_start = bus.start && (state_q != RUN);
    assign advance      = (state_q == RUN) && !bus.stall && !bus.halt;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (!bus.stall && bus.halt) state_d = DONE;
            DONE:    if (bus.start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from current state
    always_comb begin
        bus.fetch_valid = (state_q == RUN) && !bus.stall;
        bus.done        = (state_q == DONE);
    end

    // Next-PC priority resolution and stack/error side effects
    always_comb begin
        pc_d     = pc_q;
        err_d    = err_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_clr  = 1'b0;
        if (accept_start) begin
            pc_d    = '0;
            err_d   = 1'b0;
            stk_clr = 1'b1;
        end else if (advance) begin
            if (bus.ret_en) begin
                if (!stk_empty) begin
                    stk_pop = 1'b1;
                    pc_d    = stk_dout;
                end else begin
                    err_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end else if (bus.call_en) begin
                pc_d = bus.target;
                if (stk_full) begin
                    err_d = 1'b1;
                end else begin
                    stk_push = 1'b1;
                end
            end else if (bus.absjump_en || (bus.branch_en && bus.cond_flag)) begin
                pc_d = bus.target;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // Program counter and sticky stack-error registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    assign bus.prog_ctr = pc_q;
    assign bus.stk_err  = err_q;

    ret_stack #(
        .D      (D),
        .SDEPTH (SDEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .clr   (stk_clr),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .dout  (stk_dout),
        .empty (stk_empty),
        .full  (stk_full)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int unsigned D      = PC_W;
    localparam int unsigned SDEPTH = STK_DEPTH;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    logic [D-1:0] m_pc;
    bit           m_run;
    bit           m_done;
    bit           m_err;
    logic [D-1:0] m_stk[$];

    pc_sequencer_if bus_i ();

    pc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit st, input bit stl, input bit ab, input bit br, input bit cf,
                          input bit cl, input bit rt, input bit hl, input logic [D-1:0] tgt);
        bus_i.start      = st;
        bus_i.stall      = stl;
        bus_i.absjump_en = ab;
        bus_i.branch_en  = br;
        bus_i.cond_flag  = cf;
        bus_i.call_en    = cl;
        bus_i.ret_en     = rt;
        bus_i.halt       = hl;
        bus_i.target     = tgt;
    endtask

    task automatic clear_in();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, '0);
    endtask

    task automatic model_reset();
        m_pc   = '0;
        m_run  = 0;
        m_done = 0;
        m_err  = 0;
        m_stk.delete();
    endtask

    task automatic check_model(input string tag);
        chk({tag, " prog_ctr"}, 32'(bus_i.prog_ctr), 32'(m_pc));
        chk({tag, " fetch_valid"}, 32'(bus_i.fetch_valid), 32'(m_run && !bus_i.stall));
        chk({tag, " done"}, 32'(bus_i.done), 32'(m_done));
        chk({tag, " stk_err"}, 32'(bus_i.stk_err), 32'(m_err));
    endtask

    // Apply one clock edge of behaviour to the model
    task automatic model_edge();
        if (!m_run) begin
            if (bus_i.start) begin
                m_run  = 1;
                m_done = 0;
                m_pc   = '0;
                m_err  = 0;
                m_stk.delete();
            end
        end else if (bus_i.stall) begin
            // hold
        end else if (bus_i.halt) begin
            m_run  = 0;
            m_done = 1;
        end else if (bus_i.ret_en) begin
            if (m_stk.size() > 0) begin
                m_pc = m_stk.pop_back();
            end else begin
                m_err = 1;
                m_pc  = D'(m_pc + 1);
            end
        end else if (bus_i.call_en) begin
            if (m_stk.size() >= int'(SDEPTH)) m_err = 1;
            else m_stk.push_back(D'(m_pc + 1));
            m_pc = bus_i.target;
        end else if (bus_i.absjump_en || (bus_i.branch_en && bus_i.cond_flag)) begin
            m_pc = bus_i.target;
        end else begin
            m_pc = D'(m_pc + 1);
        end
    endtask

    // Called at a negedge with inputs driven; returns at the following negedge
    task automatic cycle(input string tag);
        #1;
        check_model(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        clear_in();
        model_reset();
        #2;
        check_model("por");
        @(negedge clk);
        reset = 1'b1;

        // Start and sequential fetch
        set_in(1, 0, 0, 0, 0, 0, 0, 0, '0);
        cycle("start");
        clear_in();
        for (int i = 0; i < 5; i++) begin
            chk("seq pc", 32'(bus_i.prog_ctr), 32'(i));
            cycle("seq");
        end
        chk("seq pc5", 32'(bus_i.prog_ctr), 32'h005);

        // Conditional branch and absolute jump priority
        set_in(0, 0, 0, 1, 0, 0, 0, 0, 12'h200);
        cycle("br nt");
        chk("br not taken", 32'(bus_i.prog_ctr), 32'h006);
        set_in(0, 0, 0, 1, 1, 0, 0, 0, 12'h200);
        cycle("br t");
        chk("br taken", 32'(bus_i.prog_ctr), 32'h200);
        set_in(0, 0, 1, 1, 0, 0, 0, 0, 12'h2A0);
        cycle("abs");
        chk("abs over br", 32'(bus_i.prog_ctr), 32'h2A0);

        // Nested call and return
        set_in(0, 0, 1, 0, 0, 0, 0, 0, 12'h010);
        cycle("j010");
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 12'h100);
        cycle("call1");
        chk("call1 pc", 32'(bus_i.prog_ctr), 32'h100);
        set_in(0, 0, 1, 0, 0, 0, 0, 0, 12'h102);
        cycle("j102");
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 12'h300);
        cycle("call2");
        chk("call2 pc", 32'(bus_i.prog_ctr), 32'h300);
        set_in(0, 0, 0, 0, 0, 0, 1, 0, '0);
        cycle("ret1");
        chk("ret1 pc", 32'(bus_i.prog_ctr), 32'h103);
        cycle("ret2");
        chk("ret2 pc", 32'(bus_i.prog_ctr), 32'h011);
        chk("nest err", 32'(bus_i.stk_err), 32'h0);

        // Overflow then underflow
        for (int i = 0; i <= int'(SDEPTH); i++) begin
            set_in(0, 0, 0, 0, 0, 1, 0, 0, D'(12'h400 + 16 * i));
            cycle("ovf call");
        end
        chk("ovf pc", 32'(bus_i.prog_ctr), 32'h440);
        chk("ovf err", 32'(bus_i.stk_err), 32'h1);
        set_in(0, 0, 0, 0, 0, 0, 1, 0, '0);
        for (int i = 0; i <= int'(SDEPTH); i++) cycle("unf ret");
        chk("unf pc", 32'(bus_i.prog_ctr), 32'h013);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, '0);
        cycle("halt1");
        chk("halt1 done", 32'(bus_i.done), 32'h1);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, '0);
        cycle("restart1");
        chk("restart err clr", 32'(bus_i.stk_err), 32'h0);
        chk("restart pc", 32'(bus_i.prog_ctr), 32'h000);

        // Wrap, stall, halt, restart
        set_in(0, 0, 1, 0, 0, 0, 0, 0, 12'hFFF);
        cycle("jfff");
        clear_in();
        cycle("wrap");
        chk("wrap pc", 32'(bus_i.prog_ctr), 32'h000);
        set_in(0, 1, 0, 0, 0, 1, 0, 0, 12'h555);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall fv", 32'(bus_i.fetch_valid), 32'h0);
            cycle("stall");
        end
        chk("stall pc", 32'(bus_i.prog_ctr), 32'h000);
        clear_in();
        cycle("post stall");
        set_in(0, 0, 0, 0, 0, 0, 0, 1, '0);
        cycle("halt2");
        clear_in();
        cycle("done hold");
        cycle("done hold");
        chk("frozen pc", 32'(bus_i.prog_ctr), 32'h001);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, '0);
        cycle("restart2");
        chk("restart2 done", 32'(bus_i.done), 32'h0);

        // Reset in the middle of a run
        set_in(0, 0, 1, 0, 0, 0, 0, 0, 12'h07A);
        cycle("j07a");
        clear_in();
        chk("pre-rst pc", 32'(bus_i.prog_ctr), 32'h07A);
        reset = 1'b0;
        #1;
        chk("rst pc", 32'(bus_i.prog_ctr), 32'h000);
        chk("rst done", 32'(bus_i.done), 32'h0);
        model_reset();
        check_model("rst");
        @(negedge clk);
        reset = 1'b1;
        cycle("idle");

        // Randomized control mix
        for (int n = 0; n < 600; n++) begin
            set_in($urandom_range(3) == 0, $urandom_range(4) == 0,
                   $urandom_range(7) == 0, $urandom_range(3) == 0, 1'($urandom),
                   $urandom_range(5) == 0, $urandom_range(4) == 0,
                   $urandom_range(39) == 0, D'($urandom));
            cycle("rnd");
        end
        clear_in();
        cycle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
